// File: rtl/serial_bus_pkg.sv
// -----------------------------------------------------------------------------
// serial_bus_pkg
// Shared definitions for the serial system bus: transaction state encoding,
// transfer-mode encoding and the default slave-select width. The slave port and
// the arbiter use the same values, so they must not be changed locally.
// -----------------------------------------------------------------------------
package serial_bus_pkg;

    // Port transaction states (3-bit encoding shared across the bus).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int DEFAULT_SLAVE_ADDR_WIDTH = 4;

    // Larger of two integers, used to size counters shared by two phases.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_beat_counter.sv
// -----------------------------------------------------------------------------
// serial_beat_counter
// Beat counter for serial bus ports. Counts enabled cycles from zero and flags
// the beat that equals the caller-supplied limit.
// Ports:
//   clk, rstn   clock, async active-low reset
//   clr         synchronous clear (takes priority over en)
//   en          advance by one beat
//   limit       index of the final beat of the current phase
//   cnt         current beat index
//   last        cnt == limit
// -----------------------------------------------------------------------------
module serial_beat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             last
);

    logic [WIDTH-1:0] cnt_r;

    // Beat index register: clear wins over advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + WIDTH'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign last = (cnt_r == limit);

endmodule

// File: rtl/serial_master_port.sv
// -----------------------------------------------------------------------------
// serial_master_port
// Master-side port of the serial system bus. Takes one read/write request from
// a device, requests the bus, serialises the slave memory address and (for
// writes) the data LSB-first over LANES-bit beats, and for reads reassembles the
// returned beats into a word presented with a one-cycle drvalid strobe.
// Ports:
//   clk, rstn                    clock, async active-low reset
//   dwdata, daddr, dmode, dvalid device request (dmode 0 read / 1 write)
//   dready                       port idle; request taken on dvalid & dready
//   drdata, drvalid, derr        read result, strobe, timeout flag
//   mbreq, mbgrant               arbitration handshake
//   mslave                       slave select (upper address bits) while mbreq
//   mwdata, mvalid, mmode        outgoing beats and latched mode
//   mrdata, svalid               incoming read beats
// Optional feature: define SERIAL_MASTER_TIMEOUT_EN to abort a read after
// TIMEOUT_CYCLES consecutive cycles without svalid (drvalid with derr, drdata 0).
// -----------------------------------------------------------------------------
module serial_master_port
    import serial_bus_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int SLAVE_ADDR_WIDTH = DEFAULT_SLAVE_ADDR_WIDTH,
    parameter int LANES            = 1,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [DATA_WIDTH-1:0]       dwdata,
    input  logic [ADDR_WIDTH-1:0]       daddr,
    input  logic                        dmode,
    input  logic                        dvalid,
    output logic                        dready,
    output logic [DATA_WIDTH-1:0]       drdata,
    output logic                        drvalid,
    output logic                        derr,
    output logic                        mbreq,
    input  logic                        mbgrant,
    output logic [SLAVE_ADDR_WIDTH-1:0] mslave,
    output logic [LANES-1:0]            mwdata,
    output logic                        mmode,
    output logic                        mvalid,
    input  logic [LANES-1:0]            mrdata,
    input  logic                        svalid
);

    localparam int MEM_W  = ADDR_WIDTH - SLAVE_ADDR_WIDTH;
    localparam int ABEATS = MEM_W / LANES;
    localparam int DBEATS = DATA_WIDTH / LANES;
    localparam int CW     = $clog2(max_int(ABEATS, DBEATS) + 1);

    if (((DATA_WIDTH % LANES) != 0) || ((MEM_W % LANES) != 0)) begin : g_lane_check
        $error("serial_master_port: LANES must divide DATA_WIDTH and ADDR_WIDTH-SLAVE_ADDR_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("serial_master_port: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                  state_r, state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r, rdata_r, rdata_next_s, drdata_r;
    logic                    mode_r;
    logic [CW-1:0]           beat_s, beat_limit_s;
    logic                    beat_last_s, beat_en_s, beat_clr_s;
    logic                    timeout_s;

    // Transaction state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and beat-advance enable.
    always_comb begin
        state_next_s = state_r;
        beat_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dvalid) state_next_s = ST_REQ;
                else        state_next_s = state_r;
            end
            ST_REQ: begin
                if (mbgrant) state_next_s = ST_ADDR;
                else         state_next_s = state_r;
            end
            ST_ADDR: begin
                beat_en_s = 1'b1;
                if (beat_last_s) state_next_s = (mode_r == MODE_WRITE) ? ST_WDATA : ST_RDATA;
                else             state_next_s = state_r;
            end
            ST_WDATA: begin
                beat_en_s = 1'b1;
                if (beat_last_s) state_next_s = ST_DONE;
                else             state_next_s = state_r;
            end
            ST_RDATA: begin
                beat_en_s = svalid;
                if (svalid && beat_last_s) state_next_s = ST_DONE;
                else if (timeout_s)        state_next_s = ST_DONE;
                else                       state_next_s = state_r;
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // The address phase and the data phases have different beat counts.
    always_comb begin
        if (state_r == ST_ADDR) beat_limit_s = CW'(ABEATS - 1);
        else                    beat_limit_s = CW'(DBEATS - 1);
    end

    // Any state change restarts the beat count for the next phase.
    assign beat_clr_s = (state_next_s != state_r);

    serial_beat_counter #(
        .WIDTH (CW)
    ) u_beat_counter (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (beat_clr_s),
        .en    (beat_en_s),
        .limit (beat_limit_s),
        .cnt   (beat_s),
        .last  (beat_last_s)
    );

    // Read word with the beat arriving this cycle merged in, so the final beat
    // can be published in the same edge that enters DONE.
    always_comb begin
        rdata_next_s = rdata_r;
        if ((state_r == ST_RDATA) && svalid) begin
            rdata_next_s[int'(beat_s)*LANES +: LANES] = mrdata;
        end else begin
            rdata_next_s = rdata_r;
        end
    end

    // Request latch on acceptance, read assembly and read-result register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_r   <= '0;
            wdata_r  <= '0;
            mode_r   <= MODE_READ;
            rdata_r  <= '0;
            drdata_r <= '0;
        end else if ((state_r == ST_IDLE) && dvalid) begin
            addr_r  <= daddr;
            wdata_r <= dwdata;
            mode_r  <= dmode;
            rdata_r <= '0;
        end else if (state_r == ST_RDATA) begin
            rdata_r <= rdata_next_s;
            if (state_next_s == ST_DONE) begin
                drdata_r <= timeout_s ? '0 : rdata_next_s;
            end
        end
    end

`ifdef SERIAL_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt_r;
    logic          err_r;

    // Consecutive cycles in RDATA without a slave beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idle_cnt_r <= '0;
        end else if ((state_r != ST_RDATA) || svalid) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
        end
    end

    // This cycle is the TIMEOUT_CYCLES-th silent one.
    assign timeout_s = (state_r == ST_RDATA) && !svalid &&
                       (idle_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Error flag reported alongside the aborted read strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && dvalid) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign derr = drvalid & err_r;
`else
    assign timeout_s = 1'b0;
    assign derr      = 1'b0;
`endif

    // Beat driver: zero whenever no beat is being presented.
    always_comb begin
        mwdata = '0;
        if (state_r == ST_ADDR)       mwdata = addr_r[int'(beat_s)*LANES +: LANES];
        else if (state_r == ST_WDATA) mwdata = wdata_r[int'(beat_s)*LANES +: LANES];
        else                          mwdata = '0;
    end

    assign dready  = (state_r == ST_IDLE);
    assign mbreq   = (state_r == ST_REQ) || (state_r == ST_ADDR) ||
                     (state_r == ST_WDATA) || (state_r == ST_RDATA);
    assign mvalid  = (state_r == ST_ADDR) || (state_r == ST_WDATA);
    assign mslave  = mbreq ? addr_r[ADDR_WIDTH-1 -: SLAVE_ADDR_WIDTH] : '0;
    assign mmode   = mode_r;
    assign drdata  = drdata_r;
    assign drvalid = (state_r == ST_DONE) && (mode_r == MODE_READ);

endmodule
